// File: rtl/add_seq_pkg.sv
// add_seq_pkg
//   Shared definitions for the sequential wide adder: the slice width, the
//   controller state encoding and a helper that turns an operand width into
//   the number of 4-bit slices pushed through the slice adder.
package add_seq_pkg;

  localparam int SLICE_W = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  // Number of slices needed to cover an operand of the given width.
  function automatic int nslice(input int width);
    return width / SLICE_W;
  endfunction

endpackage

// File: rtl/add_slice4.sv
// add_slice4
//   Combinational 4-bit ripple-carry adder slice. This is the only
//   arithmetic in the sequential wide adder.
//   Ports:
//     A, B  : 4-bit addends
//     Cin   : carry into bit 0
//     Sum   : 4-bit sum
//     Cout  : carry out of bit 3
module add_slice4
  import add_seq_pkg::*;
(
  input  logic [SLICE_W-1:0] A,
  input  logic [SLICE_W-1:0] B,
  input  logic               Cin,
  output logic [SLICE_W-1:0] Sum,
  output logic               Cout
);

  logic [SLICE_W:0] carry;

  // Classic full-adder chain; carry[i] is the carry into bit i.
  always_comb begin
    carry    = '0;
    Sum      = '0;
    carry[0] = Cin;
    for (int i = 0; i < SLICE_W; i++) begin
      Sum[i]       = A[i] ^ B[i] ^ carry[i];
      carry[i + 1] = (A[i] & B[i]) | (carry[i] & (A[i] ^ B[i]));
    end
    Cout = carry[SLICE_W];
  end

endmodule

// File: rtl/add_seq_wide.sv
// add_seq_wide
//   Multi-cycle WIDTH-bit adder. Operands are accepted over a valid/ready
//   handshake, pushed one 4-bit slice per clock through add_slice4 (least
//   significant slice first, carry chained through a register), and the
//   result is presented over a second valid/ready handshake.
//   Parameters:
//     WIDTH      : operand/result width, multiple of 4, minimum 4
//   Ports:
//     clk, rst_n : rising-edge clock, asynchronous active-low reset
//     in_valid   : A/B/Cin valid          in_ready  : accepting (IDLE only)
//     A, B, Cin  : addends and carry-in
//     out_valid  : Sum/Cout valid         out_ready : consumer takes result
//     Sum, Cout  : A+B+Cin and final carry
//     busy       : transaction in flight (RUN or DONE)
//     Ovf        : signed overflow, only when ADD_SEQ_OVF_EN is defined
//   Build option: define ADD_SEQ_OVF_EN to add the Ovf output and register.
module add_seq_wide
  import add_seq_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             Cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] Sum,
  output logic             Cout,
  output logic             busy
`ifdef ADD_SEQ_OVF_EN
  ,
  output logic             Ovf
`endif
);

  localparam int NSLICE = nslice(WIDTH);
  localparam int IDX_W  = (NSLICE > 1) ? $clog2(NSLICE) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NSLICE - 1);

  state_t             state;
  logic [WIDTH-1:0]   a_reg;
  logic [WIDTH-1:0]   b_reg;
  logic [WIDTH-1:0]   sum_reg;
  logic               carry;
  logic [IDX_W-1:0]   idx;

  logic [SLICE_W-1:0] slice_a;
  logic [SLICE_W-1:0] slice_b;
  logic [SLICE_W-1:0] slice_sum;
  logic               slice_cout;

  // Pick the current slice of the latched operands for the slice adder.
  always_comb begin
    slice_a = a_reg[int'(idx) * SLICE_W +: SLICE_W];
    slice_b = b_reg[int'(idx) * SLICE_W +: SLICE_W];
  end

  add_slice4 u_slice (
    .A   (slice_a),
    .B   (slice_b),
    .Cin (carry),
    .Sum (slice_sum),
    .Cout(slice_cout)
  );

  // Controller and datapath registers. Handshake outputs are registered
  // alongside the state so they change only on clock edges (or reset).
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      a_reg     <= '0;
      b_reg     <= '0;
      sum_reg   <= '0;
      carry     <= 1'b0;
      idx       <= '0;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      busy      <= 1'b0;
`ifdef ADD_SEQ_OVF_EN
      Ovf       <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            a_reg    <= A;
            b_reg    <= B;
            carry    <= Cin;
            idx      <= '0;
            sum_reg  <= '0;
            in_ready <= 1'b0;
            busy     <= 1'b1;
            state    <= RUN;
`ifdef ADD_SEQ_OVF_EN
            Ovf      <= 1'b0;
`endif
          end
        end
        RUN: begin
          sum_reg[int'(idx) * SLICE_W +: SLICE_W] <= slice_sum;
          carry <= slice_cout;
          idx   <= idx + IDX_W'(1);
          if (idx == LAST_IDX) begin
            out_valid <= 1'b1;
            state     <= DONE;
`ifdef ADD_SEQ_OVF_EN
            // Same-sign addends producing an opposite-sign result; this is
            // equivalent to carry-into-MSB XOR carry-out of the top slice.
            Ovf <= (slice_a[SLICE_W-1] ~^ slice_b[SLICE_W-1]) &
                   (slice_a[SLICE_W-1] ^ slice_sum[SLICE_W-1]);
`endif
          end
        end
        DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            busy      <= 1'b0;
            in_ready  <= 1'b1;
            state     <= IDLE;
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  assign Sum  = sum_reg;
  // The carry register holds the final carry once the last slice is done.
  assign Cout = carry;

endmodule

// File: tb/tb_add_seq_wide.sv
// tb_add_seq_wide
//   Self-checking bench for add_seq_wide at WIDTH=16: a table of directed
//   vectors, hand-written backpressure and mid-transaction reset sequences,
//   then randomized transactions checked against plain integer addition.
//   Define ADD_SEQ_OVF_EN to also check the Ovf output.
module tb_add_seq_wide;

  localparam int W = 16;

  typedef struct {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         cin;
    logic [W-1:0] exp_sum;
    logic         exp_cout;
    logic         exp_ovf;
  } vec_t;

  logic         clk;
  logic         rst_n;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         cin;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] sum;
  logic         cout;
  logic         busy;
`ifdef ADD_SEQ_OVF_EN
  logic         ovf;
`endif

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int accept_cyc = 0;
  int prev_accept = 0;
  int lat = 0;

  vec_t vecs[8];

  add_seq_wide #(.WIDTH(W)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .A        (a),
    .B        (b),
    .Cin      (cin),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .Sum      (sum),
    .Cout     (cout),
    .busy     (busy)
`ifdef ADD_SEQ_OVF_EN
    ,
    .Ovf      (ovf)
`endif
  );

  // 10 ns clock.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Free-running cycle count used for latency/throughput measurements.
  always @(posedge clk) cyc <= cyc + 1;

  // One comparison: counts it, and reports a FAIL line on mismatch.
  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h at %0t", name, actual,
               expected, $time);
    end
  endtask

  // Offer operands and wait (bounded) for the accept edge; afterwards the
  // input pins are scrambled to prove they are not sampled again.
  task automatic applyStimulus(input logic [W-1:0] va, input logic [W-1:0] vb,
                               input logic vc);
    int n;
    a        = va;
    b        = vb;
    cin      = vc;
    in_valid = 1'b1;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!in_ready && n < 50);
    checkOutput("accept_timeout", 32'(n < 50), 32'd1);
    @(posedge clk);
    #1;
    accept_cyc = cyc;
    in_valid = 1'b0;
    a        = W'($urandom);
    b        = W'($urandom);
    cin      = 1'($urandom);
  endtask

  // Count edges after the accept edge until out_valid is seen (bounded).
  task automatic waitResult(output int edges);
    int n;
    n = 0;
    while (!out_valid && n < 50) begin
      @(posedge clk);
      #1;
      n++;
    end
    edges = n;
    checkOutput("valid_timeout", 32'(out_valid), 32'd1);
  endtask

  // Reference: full-precision integer addition and the sign rule.
  task automatic checkResult(input string name, input logic [W-1:0] va,
                             input logic [W-1:0] vb, input logic vc);
    logic [W:0] full;
    logic       exp_ovf;
    full    = {1'b0, va} + {1'b0, vb} + {{W{1'b0}}, vc};
    exp_ovf = (va[W-1] == vb[W-1]) && (full[W-1] != va[W-1]);
    checkOutput({name, "_sum"}, 32'(sum), 32'(full[W-1:0]));
    checkOutput({name, "_cout"}, 32'(cout), 32'(full[W]));
`ifdef ADD_SEQ_OVF_EN
    checkOutput({name, "_ovf"}, 32'(ovf), 32'(exp_ovf));
`else
    if (exp_ovf === 1'bx) $display("[TB] ovf model undefined");
`endif
  endtask

  initial begin
    vecs[0] = '{16'h0000, 16'h0000, 1'b0, 16'h0000, 1'b0, 1'b0};
    vecs[1] = '{16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1, 1'b0};
    vecs[2] = '{16'h1234, 16'h4321, 1'b1, 16'h5556, 1'b0, 1'b0};
    vecs[3] = '{16'hFFFF, 16'hFFFF, 1'b1, 16'hFFFF, 1'b1, 1'b0};
    vecs[4] = '{16'h7FFF, 16'h0001, 1'b0, 16'h8000, 1'b0, 1'b1};
    vecs[5] = '{16'h8000, 16'hFFFF, 1'b0, 16'h7FFF, 1'b1, 1'b1};
    vecs[6] = '{16'h0001, 16'hFFFF, 1'b0, 16'h0000, 1'b1, 1'b0};
    vecs[7] = '{16'h00FF, 16'h0001, 1'b0, 16'h0100, 1'b0, 1'b0};

    rst_n     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    a         = '0;
    b         = '0;
    cin       = 1'b0;
    #23;

    // Reset state.
    checkOutput("rst_in_ready", 32'(in_ready), 32'd1);
    checkOutput("rst_out_valid", 32'(out_valid), 32'd0);
    checkOutput("rst_busy", 32'(busy), 32'd0);
    checkOutput("rst_sum", 32'(sum), 32'd0);
    checkOutput("rst_cout", 32'(cout), 32'd0);
`ifdef ADD_SEQ_OVF_EN
    checkOutput("rst_ovf", 32'(ovf), 32'd0);
`endif
    rst_n = 1'b1;
    repeat (2) @(posedge clk);
    #1;

    // Directed table, back to back with out_ready held high.
    out_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      applyStimulus(vecs[i].a, vecs[i].b, vecs[i].cin);
      if (i > 0) checkOutput("throughput", 32'(accept_cyc - prev_accept), 32'd6);
      prev_accept = accept_cyc;
      checkOutput("busy_run", 32'(busy), 32'd1);
      waitResult(lat);
      checkOutput("latency", 32'(lat), 32'd4);
      checkOutput("tbl_sum", 32'(sum), 32'(vecs[i].exp_sum));
      checkOutput("tbl_cout", 32'(cout), 32'(vecs[i].exp_cout));
`ifdef ADD_SEQ_OVF_EN
      checkOutput("tbl_ovf", 32'(ovf), 32'(vecs[i].exp_ovf));
`endif
    end
    @(posedge clk);
    #1;
    checkOutput("post_tbl_valid", 32'(out_valid), 32'd0);
    checkOutput("post_tbl_ready", 32'(in_ready), 32'd1);

    // Backpressure: result held 3 cycles, in_valid pulses ignored.
    out_ready = 1'b0;
    applyStimulus(16'hA5A5, 16'h1111, 1'b1);
    waitResult(lat);
    checkResult("bp_first", 16'hA5A5, 16'h1111, 1'b1);
    for (int k = 0; k < 3; k++) begin
      a        = W'($urandom);
      b        = W'($urandom);
      in_valid = 1'b1;
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      checkOutput("bp_valid", 32'(out_valid), 32'd1);
      checkOutput("bp_in_ready", 32'(in_ready), 32'd0);
      checkOutput("bp_busy", 32'(busy), 32'd1);
      checkResult("bp_hold", 16'hA5A5, 16'h1111, 1'b1);
    end
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    checkOutput("bp_release_valid", 32'(out_valid), 32'd0);
    checkOutput("bp_release_ready", 32'(in_ready), 32'd1);

    // Reset during the second RUN cycle.
    applyStimulus(16'hFFFF, 16'hFFFF, 1'b1);
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    checkOutput("mid_rst_in_ready", 32'(in_ready), 32'd1);
    checkOutput("mid_rst_valid", 32'(out_valid), 32'd0);
    checkOutput("mid_rst_busy", 32'(busy), 32'd0);
    checkOutput("mid_rst_sum", 32'(sum), 32'd0);
    checkOutput("mid_rst_cout", 32'(cout), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    for (int k = 0; k < 6; k++) begin
      @(posedge clk);
      #1;
      checkOutput("mid_rst_no_valid", 32'(out_valid), 32'd0);
    end
    out_ready = 1'b1;
    applyStimulus(16'h00FF, 16'h0001, 1'b0);
    waitResult(lat);
    checkOutput("post_rst_sum", 32'(sum), 32'h0100);
    checkOutput("post_rst_cout", 32'(cout), 32'd0);
    @(posedge clk);
    #1;
    out_ready = 1'b0;

    // Randomized transactions with random backpressure.
    for (int t = 0; t < 40; t++) begin
      logic [W-1:0] ra;
      logic [W-1:0] rb;
      logic         rc;
      int           hold;
      ra   = W'($urandom);
      rb   = W'($urandom);
      rc   = 1'($urandom);
      hold = $urandom_range(0, 3);
      applyStimulus(ra, rb, rc);
      waitResult(lat);
      checkOutput("rnd_latency", 32'(lat), 32'd4);
      checkResult("rnd", ra, rb, rc);
      for (int k = 0; k < hold; k++) begin
        @(posedge clk);
        #1;
        checkResult("rnd_hold", ra, rb, rc);
      end
      out_ready = 1'b1;
      @(posedge clk);
      #1;
      out_ready = 1'b0;
      checkOutput("rnd_done", 32'(out_valid), 32'd0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  // Global watchdog so the run always ends.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
